cfg_sync: RTL and testbench

- Conditions the asynchronous MCU config pins (chip, is_15khz, is_hide_raster_lines) and the clock generator lock into stable, clk_dot4x-domain configuration for vicii.
- Sequences the vicii reset and the CPU reset.
- Sits between the top-level pins and clockgen on one side and the vicii instance on the other.
- Replaces the direct wiring of pins and rst into vicii.

---
 rtl/vicii_pkg.sv | 17 +
 rtl/sync_debounce.sv | 48 ++++
 rtl/cfg_sync.sv | 129 ++++++++++++
 tb/tb_cfg_sync.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vicii_pkg.sv
// rtl/vicii_pkg.sv - shared chip and configuration-sequencer types for vicii
package vicii_pkg;

    typedef enum logic [1:0] {
        CHIP6567R8   = 2'd0,
        CHIP6569     = 2'd1,
        CHIP6567R56A = 2'd2,
        CHIP6569R1   = 2'd3
    } chip_t;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - 2-flop synchronizer plus stability debounce for a W-bit vector
module sync_debounce #(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable_vec,
    output logic         deb_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sync1, sync2, prev;
    logic [CNT_W-1:0] deb_cnt, cnt_next;

    always_comb begin
        cnt_next = deb_cnt;
        if (sync2 != prev)
            cnt_next = '0;
        else if (deb_cnt != CNT_MAX)
            cnt_next = deb_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            deb_cnt    <= '0;
            stable_vec <= '0;
            deb_valid  <= 1'b0;
        end else begin
            sync1   <= din;
            sync2   <= sync1;
            prev    <= sync2;
            deb_cnt <= cnt_next;
            // Reloading while saturated is harmless: sync2 already equals stable_vec.
            if (cnt_next == CNT_MAX) begin
                stable_vec <= sync2;
                deb_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_sync.sv
// rtl/cfg_sync.sv - conditions MCU config pins and clock lock, sequences vicii and CPU resets
module cfg_sync
    import vicii_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int RESET_HOLD      = 256,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES > RESET_HOLD ? DEBOUNCE_CYCLES : RESET_HOLD) + 1
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       locked,
    input  logic [1:0] chip_in,
    input  logic       is_15khz_in,
    input  logic       hide_in,
    input  logic       vsync,
    output logic [1:0] chip,
    output logic       is_15khz,
    output logic       is_hide_raster_lines,
    output logic       vic_rst,
    output logic       cpu_reset
);

    logic       lock_s1, locked_sync;
    logic [3:0] stable_vec;
    logic       deb_valid;
    logic       vsync_q;

    cfg_state_t       state, state_n;
    chip_t            chip_q, chip_n;
    logic             is15_q, is15_n, hide_q, hide_n;
    logic             vic_rst_q, cpu_reset_q;
    logic [CNT_W-1:0] hold_cnt, hold_n;

    chip_t stable_chip;
    logic  vsync_rise;

    sync_debounce #(
        .W               (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk        (clk_dot4x),
        .rst        (rst),
        .din        ({chip_in, is_15khz_in, hide_in}),
        .stable_vec (stable_vec),
        .deb_valid  (deb_valid)
    );

    assign stable_chip = chip_t'(stable_vec[3:2]);
    assign vsync_rise  = vsync && !vsync_q;

    always_comb begin
        state_n = state;
        chip_n  = chip_q;
        is15_n  = is15_q;
        hide_n  = hide_q;
        hold_n  = hold_cnt;
        case (state)
            WAIT_LOCK: begin
                if (locked_sync && deb_valid) begin
                    chip_n  = stable_chip;
                    is15_n  = stable_vec[1];
                    hide_n  = stable_vec[0];
                    hold_n  = '0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (!locked_sync) begin
                    state_n = WAIT_LOCK;
                end else if (stable_chip != chip_q) begin
                    chip_n = stable_chip;
                    hold_n = '0;
                end else if (hold_cnt == CNT_W'(RESET_HOLD - 1)) begin
                    state_n = RUN;
                end else begin
                    hold_n = hold_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_sync) begin
                    state_n = WAIT_LOCK;
                end else if (stable_chip != chip_q) begin
                    // New chip is presented to vicii while it is being held in reset.
                    chip_n  = stable_chip;
                    hold_n  = '0;
                    state_n = HOLD;
                end else if ((stable_vec[1] != is15_q || stable_vec[0] != hide_q) && vsync_rise) begin
                    is15_n = stable_vec[1];
                    hide_n = stable_vec[0];
                end
            end
            default: state_n = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk_dot4x) begin
        if (!rst) begin
            lock_s1     <= 1'b0;
            locked_sync <= 1'b0;
            vsync_q     <= 1'b0;
            state       <= WAIT_LOCK;
            chip_q      <= CHIP6567R8;
            is15_q      <= 1'b0;
            hide_q      <= 1'b0;
            hold_cnt    <= '0;
            vic_rst_q   <= 1'b1;
            cpu_reset_q <= 1'b1;
        end else begin
            lock_s1     <= locked;
            locked_sync <= lock_s1;
            vsync_q     <= vsync;
            state       <= state_n;
            chip_q      <= chip_n;
            is15_q      <= is15_n;
            hide_q      <= hide_n;
            hold_cnt    <= hold_n;
            vic_rst_q   <= (state_n != RUN);
            cpu_reset_q <= (state_n != RUN);
        end
    end

    assign chip                 = chip_q;
    assign is_15khz             = is15_q;
    assign is_hide_raster_lines = hide_q;
    assign vic_rst              = vic_rst_q;
    assign cpu_reset            = cpu_reset_q;

endmodule

// File: tb/tb_cfg_sync.sv
// tb/tb_cfg_sync.sv - directed self-checking bench for cfg_sync
module tb_cfg_sync;

    localparam int DEB  = 1024;
    localparam int HOLD = 256;

    logic       clk_dot4x = 1'b0;
    logic       rst = 1'b0;
    logic       locked = 1'b0;
    logic [1:0] chip_in = 2'b00;
    logic       is_15khz_in = 1'b0;
    logic       hide_in = 1'b0;
    logic       vsync = 1'b0;
    logic [1:0] chip;
    logic       is_15khz, is_hide_raster_lines, vic_rst, cpu_reset;

    int checks = 0;
    int errors = 0;

    cfg_sync #(
        .DEBOUNCE_CYCLES (DEB),
        .RESET_HOLD      (HOLD)
    ) dut (
        .clk_dot4x            (clk_dot4x),
        .rst                  (rst),
        .locked               (locked),
        .chip_in              (chip_in),
        .is_15khz_in          (is_15khz_in),
        .hide_in              (hide_in),
        .vsync                (vsync),
        .chip                 (chip),
        .is_15khz             (is_15khz),
        .is_hide_raster_lines (is_hide_raster_lines),
        .vic_rst              (vic_rst),
        .cpu_reset            (cpu_reset)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_dot4x);
        #1;
    endtask

    typedef struct {
        logic [1:0] chip_in;
        logic       k15_in;
        logic       hide_in;
        logic       vsync_pulse;
        int         cycles;
        logic [1:0] e_chip;
        logic       e_k15;
        logic       e_hide;
        logic       e_rst;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        int bad;
        int first;

        vecs[0] = '{2'b01, 1'b1, 1'b1, 1'b0, 1100, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 1'b1, 1'b1, 1'b1, 5,    2'b01, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{2'b11, 1'b1, 1'b1, 1'b0, 1400, 2'b11, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{2'b11, 1'b0, 1'b0, 1'b0, 1100, 2'b11, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{2'b11, 1'b0, 1'b0, 1'b1, 5,    2'b11, 1'b0, 1'b0, 1'b0};

        // Power-up
        chip_in = 2'b01;
        rst = 1'b0;
        repeat (5) tick();
        check("rst_chip", chip, 0);
        check("rst_k15", is_15khz, 0);
        check("rst_hide", is_hide_raster_lines, 0);
        check("rst_vic_rst", vic_rst, 1);
        check("rst_cpu_reset", cpu_reset, 1);
        rst = 1'b1;
        n = 0;
        while (n < 3000) begin
            n++;
            tick();
            if (n == 100) locked = 1'b1;
            if (n == DEB + 2) check("pwr_chip_pre", chip, 0);
            if (n == DEB + 3) begin
                check("pwr_chip_hold", chip, 1);
                check("pwr_vic_rst_hold", vic_rst, 1);
                check("pwr_cpu_hold", cpu_reset, 1);
            end
            if (vic_rst == 1'b0) break;
        end
        check("pwr_release_cycle", n, DEB + 3 + HOLD);
        check("pwr_cpu_release", cpu_reset, 0);

        // Glitch shorter than the debounce window
        bad = 0;
        chip_in = 2'b10;
        repeat (DEB - 10) begin
            tick();
            if (vic_rst || chip != 2'b01) bad++;
        end
        chip_in = 2'b01;
        repeat (1100) begin
            tick();
            if (vic_rst || chip != 2'b01) bad++;
        end
        check("glitch_disturbed_cycles", bad, 0);

        // Frame-aligned commit of is_15khz
        is_15khz_in = 1'b1;
        repeat (1100) tick();
        check("k15_no_vsync", is_15khz, 0);
        vsync = 1'b1;
        tick();
        check("k15_after_vsync", is_15khz, 1);
        check("k15_vic_rst", vic_rst, 0);
        vsync = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            chip_in     = vecs[i].chip_in;
            is_15khz_in = vecs[i].k15_in;
            hide_in     = vecs[i].hide_in;
            if (vecs[i].vsync_pulse) begin
                vsync = 1'b1;
                tick();
                vsync = 1'b0;
            end
            repeat (vecs[i].cycles) tick();
            check($sformatf("vec%0d_chip", i), chip, vecs[i].e_chip);
            check($sformatf("vec%0d_k15", i), is_15khz, vecs[i].e_k15);
            check($sformatf("vec%0d_hide", i), is_hide_raster_lines, vecs[i].e_hide);
            check($sformatf("vec%0d_vic_rst", i), vic_rst, vecs[i].e_rst);
            check($sformatf("vec%0d_cpu_reset", i), cpu_reset, vecs[i].e_rst);
        end

        // Permanent chip change: exact latency and hold length
        chip_in = 2'b10;
        n = 0;
        while (n < 1200) begin
            n++;
            tick();
            if (vic_rst) break;
        end
        check("chg_latency", n, DEB + 3);
        check("chg_chip", chip, 2);
        check("chg_cpu_reset", cpu_reset, 1);
        n = 0;
        while (vic_rst && n < 400) begin
            tick();
            n++;
        end
        check("chg_hold_cycles", n, HOLD);
        check("chg_cpu_release", cpu_reset, 0);

        // Lock loss for 3 cycles
        locked = 1'b0;
        n = 0;
        first = 0;
        repeat (3) begin
            tick();
            n++;
            if (vic_rst && first == 0) first = n;
        end
        locked = 1'b1;
        check("lock_rise_cycle", first, 3);
        check("lock_cpu_reset", cpu_reset, 1);
        while (n < 600) begin
            n++;
            tick();
            if (!vic_rst) break;
        end
        check("lock_release_cycle", n, 6 + HOLD);

        // Reset asserted at hold_cnt == 50
        locked = 1'b0;
        repeat (3) tick();
        locked = 1'b1;
        repeat (53) tick();
        check("midhold_vic_rst", vic_rst, 1);
        check("midhold_chip", chip, 2);
        rst = 1'b0;
        tick();
        check("midhold_rst_chip", chip, 0);
        check("midhold_rst_k15", is_15khz, 0);
        check("midhold_rst_hide", is_hide_raster_lines, 0);
        check("midhold_rst_vic_rst", vic_rst, 1);
        check("midhold_rst_cpu", cpu_reset, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
